// File: rtl/core_ifetch_pkg.sv
// Shared types and constants for the prefetching instruction fetch stage.
package core_ifetch_pkg;

    localparam logic [31:0] NOP_INSTR     = 32'h00000013;
    localparam logic [1:0]  AXI_RESP_OKAY = 2'b00;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        err;
    } entry_t;

endpackage

// File: rtl/core_ifetch_prefetch_if.sv
// AXI-lite read channels plus the decode-side instruction stream and redirect.
interface core_ifetch_prefetch_if #(
    parameter int AXI_AWIDTH = 32,
    parameter int AXI_DWIDTH = 32
);
    logic [AXI_AWIDTH-1:0] AXI_ARADDR;
    logic                  AXI_ARVALID;
    logic                  AXI_ARREADY;
    logic [AXI_DWIDTH-1:0] AXI_RDATA;
    logic [1:0]            AXI_RRESP;
    logic                  AXI_RVALID;
    logic                  AXI_RREADY;
    logic [31:0]           INSTR;
    logic [31:0]           INSTR_PC;
    logic                  INSTR_ERR;
    logic                  INSTR_VALID;
    logic                  INSTR_READY;
    logic                  REDIRECT;
    logic [31:0]           REDIRECT_PC;
    logic                  IDLE;

    modport master (
        output AXI_ARADDR, AXI_ARVALID, AXI_RREADY,
        output INSTR, INSTR_PC, INSTR_ERR, INSTR_VALID, IDLE,
        input  AXI_ARREADY, AXI_RDATA, AXI_RRESP, AXI_RVALID,
        input  INSTR_READY, REDIRECT, REDIRECT_PC
    );

    modport slave (
        input  AXI_ARADDR, AXI_ARVALID, AXI_RREADY,
        input  INSTR, INSTR_PC, INSTR_ERR, INSTR_VALID, IDLE,
        output AXI_ARREADY, AXI_RDATA, AXI_RRESP, AXI_RVALID,
        output INSTR_READY, REDIRECT, REDIRECT_PC
    );
endinterface

// File: rtl/core_ifetch_tagq.sv
// Generic synchronous FIFO with occupancy count; storage is not reset.
module core_ifetch_tagq #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty,
    output logic             full,
    output logic [CW-1:0]    count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) wr_ptr <= next_ptr(wr_ptr);
            if (pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign pop_data = mem[rd_ptr];
    assign empty    = (count_q == '0);
    assign full     = (count_q == CW'(DEPTH));
    assign count    = count_q;
endmodule

// File: rtl/core_ifetch_prefetch.sv
// Prefetching fetch stage: decoupled AR/R, epoch-tagged responses, instruction queue.
// Optional IFETCH_PERF_CNT_EN adds saturating fetch/drop counters.
module core_ifetch_prefetch
    import core_ifetch_pkg::*;
#(
    parameter logic [31:0] PC_INIT         = 32'h0,
    parameter int          AXI_AWIDTH      = 32,
    parameter int          AXI_DWIDTH      = 32,
    parameter int          FIFO_DEPTH      = 4,
    parameter int          MAX_OUTSTANDING = 2
) (
    input logic CLK,
    input logic RST,
    core_ifetch_prefetch_if.master bus
`ifdef IFETCH_PERF_CNT_EN
    ,
    output logic [31:0] PERF_FETCH_CNT,
    output logic [31:0] PERF_DROP_CNT
`endif
);
    localparam int TCW = $clog2(MAX_OUTSTANDING + 1);
    localparam int QCW = $clog2(FIFO_DEPTH + 1);

    state_t                state_q, state_d;
    logic                  epoch_q;
    logic [31:0]           fetch_pc_q;
    logic [31:0]           rsp_pc_q;
    logic                  ar_pend_q;
    logic                  ar_stale_q;
    logic [AXI_AWIDTH-1:0] ar_addr_q;
    logic [AXI_AWIDTH-1:0] araddr_w;

    logic           tag_in, tag_out, tag_empty, tag_full;
    logic [TCW-1:0] tag_cnt;
    entry_t         q_in, head;
    logic [64:0]    q_out;
    logic           q_empty, q_full, q_pop;
    logic [QCW-1:0] q_cnt;

    logic ar_hs, r_hs, stale_hs, can_issue, beat_keep, beat_err;

    // Outstanding reads are exactly the occupancy of the tag queue.
    assign can_issue = (state_q == RUN) && !tag_full && !q_full &&
                       (32'(tag_cnt) + 32'(q_cnt) < 32'(FIFO_DEPTH)) &&
                       !bus.REDIRECT && !RST;

    assign araddr_w        = ar_pend_q ? ar_addr_q : AXI_AWIDTH'(fetch_pc_q);
    assign bus.AXI_ARADDR  = araddr_w;
    assign bus.AXI_ARVALID = !RST && (ar_pend_q || can_issue);
    assign bus.AXI_RREADY  = !RST;

    assign ar_hs     = bus.AXI_ARVALID && bus.AXI_ARREADY;
    assign r_hs      = bus.AXI_RVALID && bus.AXI_RREADY;
    assign stale_hs  = ar_pend_q && ar_stale_q;
    assign tag_in    = stale_hs ? ~epoch_q : epoch_q;
    assign beat_keep = r_hs && (tag_out == epoch_q) && !bus.REDIRECT;
    assign beat_err  = (bus.AXI_RRESP != AXI_RESP_OKAY);

    assign q_in = '{instr: bus.AXI_RDATA[31:0], pc: rsp_pc_q, err: beat_err};
    assign head = entry_t'(q_out);

    assign bus.INSTR_VALID = !q_empty && !bus.REDIRECT;
    assign q_pop           = bus.INSTR_VALID && bus.INSTR_READY;
    assign bus.INSTR       = q_empty ? NOP_INSTR : head.instr;
    assign bus.INSTR_PC    = q_empty ? 32'h0 : head.pc;
    assign bus.INSTR_ERR   = !q_empty && head.err;
    assign bus.IDLE        = tag_empty && q_empty;

    core_ifetch_tagq #(.WIDTH(1), .DEPTH(MAX_OUTSTANDING)) u_tagq (
        .clk(CLK), .rst(RST), .clr(1'b0),
        .push(ar_hs), .push_data(tag_in),
        .pop(r_hs), .pop_data(tag_out),
        .empty(tag_empty), .full(tag_full), .count(tag_cnt)
    );

    core_ifetch_tagq #(.WIDTH(65), .DEPTH(FIFO_DEPTH)) u_instq (
        .clk(CLK), .rst(RST), .clr(bus.REDIRECT),
        .push(beat_keep), .push_data(q_in),
        .pop(q_pop), .pop_data(q_out),
        .empty(q_empty), .full(q_full), .count(q_cnt)
    );

    always_comb begin
        state_d = state_q;
        if (bus.REDIRECT)               state_d = RUN;
        else if (beat_keep && beat_err) state_d = HALT;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= RUN;
            epoch_q    <= 1'b0;
            fetch_pc_q <= PC_INIT;
            rsp_pc_q   <= PC_INIT;
            ar_pend_q  <= 1'b0;
            ar_stale_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ar_pend_q <= bus.AXI_ARVALID && !bus.AXI_ARREADY;
            // A request held across a redirect belongs to the previous epoch.
            if (!ar_pend_q)        ar_stale_q <= 1'b0;
            else if (bus.REDIRECT) ar_stale_q <= 1'b1;
            if (bus.REDIRECT) begin
                epoch_q    <= ~epoch_q;
                fetch_pc_q <= bus.REDIRECT_PC & ~32'h3;
                rsp_pc_q   <= bus.REDIRECT_PC & ~32'h3;
            end else begin
                if (ar_hs && !stale_hs) fetch_pc_q <= fetch_pc_q + 32'd4;
                if (beat_keep)          rsp_pc_q   <= rsp_pc_q + 32'd4;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!ar_pend_q) ar_addr_q <= araddr_w;
    end

`ifdef IFETCH_PERF_CNT_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            PERF_FETCH_CNT <= '0;
            PERF_DROP_CNT  <= '0;
        end else begin
            if (ar_hs && (PERF_FETCH_CNT != '1))
                PERF_FETCH_CNT <= PERF_FETCH_CNT + 32'd1;
            if (r_hs && !beat_keep && (PERF_DROP_CNT != '1))
                PERF_DROP_CNT <= PERF_DROP_CNT + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_core_ifetch_prefetch.sv
// Directed bench for core_ifetch_prefetch with an AXI slave model and an instruction scoreboard.
module tb_core_ifetch_prefetch;
    logic CLK;
    logic RST;

    core_ifetch_prefetch_if bus ();

`ifdef IFETCH_PERF_CNT_EN
    logic [31:0] perf_fetch;
    logic [31:0] perf_drop;
`endif

    core_ifetch_prefetch dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus.master)
`ifdef IFETCH_PERF_CNT_EN
        ,
        .PERF_FETCH_CNT(perf_fetch),
        .PERF_DROP_CNT(perf_drop)
`endif
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        err;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] ar_log[$];
    logic [31:0] rq[$];
    int          cons_cyc[$];
    int          pass_cnt = 0;
    int          total    = 0;
    int          cons_cnt = 0;
    int          cyc      = 0;
    logic        rhold;
    logic [31:0] err_addr;
    logic [31:0] addr_a;
    int          idx;

    logic        s_ar_hs, s_r_hs, s_rst;
    logic [31:0] s_ar_a;

    initial begin
        CLK = 0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] expv);
        total++;
        assert (obs === expv) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic push_exp(input logic [31:0] pc0, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.pc    = pc0 + 32'(4 * i);
            e.instr = ~e.pc;
            e.err   = (e.pc == err_addr);
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_cons(input int n);
        int k;
        k = 0;
        while (cons_cnt < n && k < 300) begin
            @(negedge CLK);
            #1;
            k++;
        end
        chk("wait_consumed", 96'(cons_cnt >= n), 96'(1));
        step();
    endtask

    task automatic wait_ar(input int n);
        int k;
        k = 0;
        while (ar_log.size() < n && k < 300) begin
            @(negedge CLK);
            #1;
            k++;
        end
        chk("wait_ar", 96'(ar_log.size() >= n), 96'(1));
        step();
    endtask

    task automatic pulse_redirect(input logic [31:0] pc);
        bus.REDIRECT    = 1'b1;
        bus.REDIRECT_PC = pc;
        step();
        bus.REDIRECT    = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string pfx);
        chk({pfx, "_arvalid"},    96'(bus.AXI_ARVALID), 96'(0));
        chk({pfx, "_instr_valid"}, 96'(bus.INSTR_VALID), 96'(0));
        chk({pfx, "_instr"},      96'(bus.INSTR),       96'(32'h00000013));
        chk({pfx, "_instr_pc"},   96'(bus.INSTR_PC),    96'(0));
        chk({pfx, "_instr_err"},  96'(bus.INSTR_ERR),   96'(0));
        chk({pfx, "_idle"},       96'(bus.IDLE),        96'(1));
    endtask

    // AXI slave: accepts per ARREADY, answers in order one cycle after acceptance.
    initial begin
        bus.AXI_RVALID = 1'b0;
        bus.AXI_RDATA  = '0;
        bus.AXI_RRESP  = 2'b00;
        forever begin
            @(negedge CLK);
            s_ar_hs = bus.AXI_ARVALID && bus.AXI_ARREADY;
            s_ar_a  = bus.AXI_ARADDR;
            s_r_hs  = bus.AXI_RVALID && bus.AXI_RREADY;
            s_rst   = RST;
            @(posedge CLK);
            #1;
            bus.AXI_RVALID = 1'b0;
            if (s_rst) begin
                rq.delete();
            end else begin
                if (s_r_hs && rq.size() > 0) void'(rq.pop_front());
                if (s_ar_hs) begin
                    rq.push_back(s_ar_a);
                    ar_log.push_back(s_ar_a);
                end
                if (!rhold && rq.size() > 0) begin
                    bus.AXI_RVALID = 1'b1;
                    bus.AXI_RDATA  = ~rq[0];
                    bus.AXI_RRESP  = (rq[0] == err_addr) ? 2'b10 : 2'b00;
                end
            end
        end
    end

    // Decode-side scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            cyc++;
            if (bus.INSTR_VALID && bus.INSTR_READY) begin
                cons_cnt++;
                cons_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    chk("instr_unexpected", {bus.INSTR_PC, bus.INSTR, 32'(bus.INSTR_ERR)}, 96'h0);
                end else begin
                    e = exp_q.pop_front();
                    chk("instr", {bus.INSTR_PC, bus.INSTR, 32'(bus.INSTR_ERR)},
                        {e.pc, e.instr, 32'(e.err)});
                end
            end
        end
    end

    initial begin
        RST             = 1'b1;
        bus.AXI_ARREADY = 1'b1;
        bus.INSTR_READY = 1'b0;
        bus.REDIRECT    = 1'b0;
        bus.REDIRECT_PC = '0;
        rhold           = 1'b0;
        err_addr        = 32'hFFFF_FFF0;

        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk_reset_outputs("reset");
        step();
        RST = 1'b0;

        // Sustained streaming from PC_INIT.
        push_exp(32'h0, 16);
        bus.INSTR_READY = 1'b1;
        @(negedge CLK);
        chk("rready_after_reset", 96'(bus.AXI_RREADY), 96'(1));
        wait_cons(16);
        bus.INSTR_READY = 1'b0;
        chk("throughput", 96'(cons_cyc[15] - cons_cyc[0]), 96'(15));
        chk("araddr0", 96'(ar_log[0]), 96'(32'h0));
        chk("araddr1", 96'(ar_log[1]), 96'(32'h4));
        chk("araddr2", 96'(ar_log[2]), 96'(32'h8));

        // Back-pressure: queue fills, fetch stops.
        repeat (20) @(posedge CLK);
        @(negedge CLK);
        chk("stall_arvalid", 96'(bus.AXI_ARVALID), 96'(0));
        chk("stall_ar_count", 96'(ar_log.size()), 96'(20));
        chk("stall_instr_valid", 96'(bus.INSTR_VALID), 96'(1));
        chk("stall_idle", 96'(bus.IDLE), 96'(0));
        step();
        push_exp(32'h40, 4);
        bus.INSTR_READY = 1'b1;
        wait_cons(20);
        bus.INSTR_READY = 1'b0;
        repeat (10) step();

        // Redirect with two reads in flight, then another redirect.
        idx   = ar_log.size();
        chk("refill_ar_count", 96'(idx), 96'(24));
        rhold = 1'b1;
        pulse_redirect(32'h100);
        wait_ar(idx + 2);
        @(negedge CLK);
        chk("inflight_arvalid", 96'(bus.AXI_ARVALID), 96'(0));
        chk("inflight_queue_flushed", 96'(bus.INSTR_VALID), 96'(0));
        chk("inflight_addr0", 96'(ar_log[idx]), 96'(32'h100));
        chk("inflight_addr1", 96'(ar_log[idx + 1]), 96'(32'h104));
        step();
        push_exp(32'h300, 4);
        rhold           = 1'b0;
        bus.INSTR_READY = 1'b1;
        pulse_redirect(32'h302);
        wait_cons(24);
        bus.INSTR_READY = 1'b0;
        chk("redirect_addr", 96'(ar_log[idx + 2]), 96'(32'h300));
`ifdef IFETCH_PERF_CNT_EN
        chk("perf_drop", 96'(perf_drop), 96'(2));
`endif

        // Request held across a redirect.
        bus.AXI_ARREADY = 1'b0;
        step();
        @(negedge CLK);
        addr_a = bus.AXI_ARADDR;
        idx    = ar_log.size();
        chk("hold_arvalid", 96'(bus.AXI_ARVALID), 96'(1));
        repeat (3) step();
        @(negedge CLK);
        chk("hold_addr_stable", 96'(bus.AXI_ARADDR), 96'(addr_a));
        step();
        pulse_redirect(32'h200);
        @(negedge CLK);
        chk("hold_addr_after_redirect", 96'(bus.AXI_ARADDR), 96'(addr_a));
        chk("hold_arvalid_after_redirect", 96'(bus.AXI_ARVALID), 96'(1));
        step();
        push_exp(32'h200, 4);
        bus.AXI_ARREADY = 1'b1;
        bus.INSTR_READY = 1'b1;
        wait_cons(28);
        bus.INSTR_READY = 1'b0;
        chk("held_addr_accepted", 96'(ar_log[idx]), 96'(addr_a));
        chk("post_hold_addr", 96'(ar_log[idx + 1]), 96'(32'h200));
        repeat (10) step();

        // Bus error halts fetch until the next redirect.
        err_addr = 32'h8;
        push_exp(32'h0, 4);
        bus.INSTR_READY = 1'b1;
        pulse_redirect(32'h0);
        wait_cons(32);
        repeat (10) step();
        @(negedge CLK);
        chk("halt_arvalid", 96'(bus.AXI_ARVALID), 96'(0));
        chk("halt_idle", 96'(bus.IDLE), 96'(1));
        chk("halt_last_addr", 96'(ar_log[ar_log.size() - 1]), 96'(32'hC));
        step();
        err_addr = 32'hFFFF_FFF0;
        idx      = ar_log.size();
        push_exp(32'h40, 4);
        pulse_redirect(32'h40);
        wait_cons(36);
        bus.INSTR_READY = 1'b0;
        chk("resume_addr", 96'(ar_log[idx]), 96'(32'h40));
        repeat (10) step();

        // Reset with two reads outstanding.
        rhold = 1'b1;
        idx   = ar_log.size();
        pulse_redirect(32'h500);
        wait_ar(idx + 2);
        RST = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        chk_reset_outputs("midreset");
        step();
        RST   = 1'b0;
        rhold = 1'b0;
        idx   = ar_log.size();
        push_exp(32'h0, 4);
        bus.INSTR_READY = 1'b1;
        wait_cons(40);
        bus.INSTR_READY = 1'b0;
        chk("restart_addr", 96'(ar_log[idx]), 96'(32'h0));
        repeat (5) step();
        chk("scoreboard_drained", 96'(exp_q.size()), 96'(0));

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
